// File: rtl/xor_perm_stage_if.sv
`timescale 1ns/1ps
// Transfer bundle for xor_perm_stage. State word x0 is element [0]; data/cipher carry x0 in the MSBs.
interface xor_perm_stage_if #(
    parameter int unsigned RATE_WORDS = 1
);
    logic                       valid_i;
    logic                       ready_o;
    logic [2:0]                 op_i;
    logic                       dom_sep_i;
    logic [64*RATE_WORDS-1:0]   data_i;
    logic [4:0][63:0]           state_i;

    logic                       valid_o;
    logic                       ready_i;
    logic [4:0][63:0]           state_o;
    logic [64*RATE_WORDS-1:0]   cipher_o;
    logic [127:0]               tag_o;
    logic                       tag_valid_o;
    logic                       err_o;

    modport slave (
        input  valid_i, op_i, dom_sep_i, data_i, state_i, ready_i,
        output ready_o, valid_o, state_o, cipher_o, tag_o, tag_valid_o, err_o
    );

    modport master (
        output valid_i, op_i, dom_sep_i, data_i, state_i, ready_i,
        input  ready_o, valid_o, state_o, cipher_o, tag_o, tag_valid_o, err_o
    );
endinterface

// File: rtl/xor_perm_stage.sv
`timescale 1ns/1ps
// Registered XOR stage around the ASCON permutation: rate absorption, key injection,
// tag extraction and domain separation behind a one-deep valid/ready register.
module xor_perm_stage #(
    parameter int unsigned RATE_WORDS = 1,
    parameter int unsigned KEY_WIDTH  = 128
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 key_load_i,
    input  logic [KEY_WIDTH-1:0] key_i,
    xor_perm_stage_if.slave      bus
);

    localparam int unsigned DW = 64 * RATE_WORDS;
    // Word indices of the capacity pair keyed during FINAL_BEGIN.
    localparam logic [2:0] FIN_HI = 3'(RATE_WORDS);
    localparam logic [2:0] FIN_LO = 3'(RATE_WORDS + 1);

    typedef enum logic [2:0] {
        OP_PASS        = 3'd0,
        OP_INIT_END    = 3'd1,
        OP_ABSORB_AD   = 3'd2,
        OP_ABSORB_PT   = 3'd3,
        OP_ABSORB_CT   = 3'd4,
        OP_FINAL_BEGIN = 3'd5,
        OP_TAG         = 3'd6,
        OP_ILLEGAL     = 3'd7
    } op_e;

    if (RATE_WORDS != 1 && RATE_WORDS != 2) begin : g_bad_rate
        $error("xor_perm_stage: RATE_WORDS must be 1 or 2");
    end
    if (KEY_WIDTH != 128) begin : g_bad_key
        $error("xor_perm_stage: KEY_WIDTH must be 128");
    end

    logic [KEY_WIDTH-1:0] key_q,       key_d;
    logic                 valid_q,     valid_d;
    logic [4:0][63:0]     state_q,     state_d;
    logic [DW-1:0]        cipher_q,    cipher_d;
    logic [127:0]         tag_q,       tag_d;
    logic                 tag_valid_q, tag_valid_d;
    logic                 err_q,       err_d;

    op_e                  op;
    logic                 ready;
    logic                 xfer;
    logic [63:0]          key_hi;
    logic [63:0]          key_lo;
    logic [4:0][63:0]     res_state;
    logic [DW-1:0]        res_cipher;
    logic [127:0]         res_tag;
    logic                 res_illegal;

    function automatic logic [63:0] data_word(input logic [DW-1:0] d, input int unsigned w);
        return d[DW-1-64*w -: 64];
    endfunction

    assign op     = op_e'(bus.op_i);
    assign key_hi = key_q[KEY_WIDTH-1 -: 64];
    assign key_lo = key_q[63:0];
    assign ready  = !valid_q || bus.ready_i;
    assign xfer   = bus.valid_i && ready;

    always_comb begin
        res_state   = bus.state_i;
        res_cipher  = cipher_q;
        res_tag     = tag_q;
        res_illegal = 1'b0;
        case (op)
            OP_PASS: begin
            end
            OP_INIT_END: begin
                res_state[3] = bus.state_i[3] ^ key_hi;
                res_state[4] = bus.state_i[4] ^ key_lo;
            end
            OP_ABSORB_AD: begin
                for (int unsigned w = 0; w < RATE_WORDS; w++) begin
                    res_state[3'(w)] = bus.state_i[3'(w)] ^ data_word(bus.data_i, w);
                end
            end
            OP_ABSORB_PT: begin
                for (int unsigned w = 0; w < RATE_WORDS; w++) begin
                    res_state[3'(w)] = bus.state_i[3'(w)] ^ data_word(bus.data_i, w);
                    res_cipher[DW-1-64*w -: 64] = res_state[3'(w)];
                end
            end
            OP_ABSORB_CT: begin
                // Decrypt: plaintext goes out, the ciphertext itself becomes the new rate.
                for (int unsigned w = 0; w < RATE_WORDS; w++) begin
                    res_cipher[DW-1-64*w -: 64] = bus.state_i[3'(w)] ^ data_word(bus.data_i, w);
                    res_state[3'(w)] = data_word(bus.data_i, w);
                end
            end
            OP_FINAL_BEGIN: begin
                for (int unsigned w = 0; w < RATE_WORDS; w++) begin
                    res_state[3'(w)] = bus.state_i[3'(w)] ^ data_word(bus.data_i, w);
                end
                res_state[FIN_HI] = bus.state_i[FIN_HI] ^ key_hi;
                res_state[FIN_LO] = bus.state_i[FIN_LO] ^ key_lo;
            end
            OP_TAG: begin
                res_tag = {bus.state_i[3], bus.state_i[4]} ^ key_q[127:0];
            end
            OP_ILLEGAL: begin
                res_illegal = 1'b1;
            end
        endcase
        res_state[4][0] = res_state[4][0] ^ bus.dom_sep_i;
    end

    always_comb begin
        key_d       = key_load_i ? key_i : key_q;
        valid_d     = valid_q;
        state_d     = state_q;
        cipher_d    = cipher_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        err_d       = err_q;
        if (xfer) begin
            valid_d     = 1'b1;
            state_d     = res_state;
            cipher_d    = res_cipher;
            tag_d       = res_tag;
            tag_valid_d = (op == OP_TAG);
            err_d       = err_q | res_illegal;
        end else if (bus.ready_i) begin
            valid_d     = 1'b0;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            key_q       <= '0;
            valid_q     <= 1'b0;
            state_q     <= '0;
            cipher_q    <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            key_q       <= key_d;
            valid_q     <= valid_d;
            state_q     <= state_d;
            cipher_q    <= cipher_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.ready_o     = ready;
    assign bus.valid_o     = valid_q;
    assign bus.state_o     = state_q;
    assign bus.cipher_o    = cipher_q;
    assign bus.tag_o       = tag_q;
    assign bus.tag_valid_o = tag_valid_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_xor_perm_stage.sv
`timescale 1ns/1ps
// Directed scoreboard bench: a RATE_WORDS=1 and a RATE_WORDS=2 instance share clock, reset, key and ready.
module tb_xor_perm_stage;

    typedef logic [4:0][63:0] st_t;
    typedef struct {
        st_t          st;
        logic [127:0] ci;
        logic [127:0] tag;
        logic         tv;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         kl;
    logic [127:0] kin;
    logic         rdy;
    int           checks = 0;
    int           errors = 0;

    exp_t         q1[$];
    exp_t         q2[$];
    exp_t         e1;
    exp_t         e2;
    logic [127:0] mkey;
    logic [127:0] mci  [1:2];
    logic [127:0] mtag [1:2];
    logic         merr [1:2];

    always #5 clk = ~clk;

    xor_perm_stage_if #(.RATE_WORDS(1)) b1();
    xor_perm_stage_if #(.RATE_WORDS(2)) b2();

    assign b1.ready_i = rdy;
    assign b2.ready_i = rdy;

    xor_perm_stage #(.RATE_WORDS(1), .KEY_WIDTH(128)) u1 (
        .clock_i(clk), .reset_i(rst), .key_load_i(kl), .key_i(kin), .bus(b1.slave)
    );
    xor_perm_stage #(.RATE_WORDS(2), .KEY_WIDTH(128)) u2 (
        .clock_i(clk), .reset_i(rst), .key_load_i(kl), .key_i(kin), .bus(b2.slave)
    );

    task automatic cmp(input string tag, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input int rw, input logic [2:0] op, input logic dom,
                                   input logic [127:0] data, input st_t s, input logic [127:0] k,
                                   input logic [127:0] ci_prev, input logic [127:0] tag_prev,
                                   input logic err_prev);
        exp_t         e;
        logic [127:0] r;
        logic [127:0] dd;
        e.st  = s;
        e.ci  = ci_prev;
        e.tag = tag_prev;
        e.tv  = (op == 3'd6);
        e.err = err_prev | (op == 3'd7);
        dd = (rw == 1) ? {64'h0, data[63:0]} : data;
        r  = (rw == 1) ? {64'h0, s[0]} : {s[0], s[1]};
        case (op)
            3'd1: {e.st[3], e.st[4]} = {s[3], s[4]} ^ k;
            3'd2: r = r ^ dd;
            3'd3: begin r = r ^ dd; e.ci = r; end
            3'd4: begin e.ci = r ^ dd; r = dd; end
            3'd5: begin
                r = r ^ dd;
                if (rw == 1) {e.st[1], e.st[2]} = {s[1], s[2]} ^ k;
                else         {e.st[2], e.st[3]} = {s[2], s[3]} ^ k;
            end
            3'd6: e.tag = {s[3], s[4]} ^ k;
            default: ;
        endcase
        if (rw == 1) e.st[0] = r[63:0];
        else         {e.st[0], e.st[1]} = r;
        e.st[4][0] = e.st[4][0] ^ dom;
        return e;
    endfunction

    task automatic setin(input int d, input logic v, input logic [2:0] op, input logic dom,
                         input logic [127:0] data, input st_t s);
        if (d == 1) begin
            b1.valid_i = v; b1.op_i = op; b1.dom_sep_i = dom; b1.data_i = data[63:0]; b1.state_i = s;
        end else begin
            b2.valid_i = v; b2.op_i = op; b2.dom_sep_i = dom; b2.data_i = data; b2.state_i = s;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that registered the result.
    task automatic xfer(input int d, input logic [2:0] op, input logic dom, input logic [127:0] data,
                        input st_t s, input logic kload, input logic [127:0] knew);
        int   n;
        logic ok;
        exp_t e;
        setin(d, 1'b1, op, dom, data, s);
        kl  = kload;
        kin = knew;
        n   = 0;
        ok  = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = (d == 1) ? b1.ready_o : b2.ready_o;
            n++;
        end
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL xfer_timeout got ready_o=0 exp ready_o=1");
        end
        if (ok) begin
            e = model(d, op, dom, data, s, mkey, mci[d], mtag[d], merr[d]);
            mci[d]  = e.ci;
            mtag[d] = e.tag;
            merr[d] = e.err;
            if (d == 1) q1.push_back(e);
            else        q2.push_back(e);
        end
        @(posedge clk);
        #1;
        if (kload) mkey = knew;
        kl = 1'b0;
        setin(d, 1'b0, op, dom, data, s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic loadkey(input logic [127:0] k);
        kl  = 1'b1;
        kin = k;
        @(posedge clk);
        #1;
        kl   = 1'b0;
        mkey = k;
    endtask

    always @(negedge clk) begin
        if (!rst && b1.valid_o && b1.ready_i) begin
            checks++;
            assert (q1.size() != 0) else begin
                errors++;
                $error("FAIL sb1_unexpected got valid_o=1 exp no result");
            end
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                cmp("sb1_state", b1.state_o, e1.st);
                cmp("sb1_cipher", b1.cipher_o, e1.ci);
                cmp("sb1_tag", b1.tag_o, e1.tag);
                cmp("sb1_tag_valid", b1.tag_valid_o, e1.tv);
                cmp("sb1_err", b1.err_o, e1.err);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b2.valid_o && b2.ready_i) begin
            checks++;
            assert (q2.size() != 0) else begin
                errors++;
                $error("FAIL sb2_unexpected got valid_o=1 exp no result");
            end
            if (q2.size() != 0) begin
                e2 = q2.pop_front();
                cmp("sb2_state", b2.state_o, e2.st);
                cmp("sb2_cipher", b2.cipher_o, e2.ci);
                cmp("sb2_tag", b2.tag_o, e2.tag);
                cmp("sb2_tag_valid", b2.tag_valid_o, e2.tv);
                cmp("sb2_err", b2.err_o, e2.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        st_t  s;
        st_t  pa;
        st_t  pb;
        time  t0;
        rst  = 1'b1;
        kl   = 1'b0;
        kin  = '0;
        rdy  = 1'b1;
        mkey = '0;
        for (int i = 1; i <= 2; i++) begin
            mci[i] = '0; mtag[i] = '0; merr[i] = 1'b0;
            setin(i, 1'b0, 3'd0, 1'b0, '0, '0);
        end
        #12;
        cmp("rst_valid", b1.valid_o, 1'b0);
        cmp("rst_ready", b1.ready_o, 1'b1);
        cmp("rst_state", b1.state_o, '0);
        cmp("rst_cipher", b1.cipher_o, '0);
        cmp("rst_tag", b1.tag_o, '0);
        cmp("rst_tag_valid", b1.tag_valid_o, 1'b0);
        cmp("rst_err", b1.err_o, 1'b0);
        cmp("rst_state2", b2.state_o, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // INIT_END with and without domain separation
        loadkey(128'h000102030405060708090A0B0C0D0E0F);
        s = '0;
        xfer(1, 3'd1, 1'b0, '0, s, 1'b0, '0);
        cmp("init_valid", b1.valid_o, 1'b1);
        cmp("init_x3", b1.state_o[3], 64'h0001020304050607);
        cmp("init_x4", b1.state_o[4], 64'h08090A0B0C0D0E0F);
        xfer(1, 3'd1, 1'b1, '0, s, 1'b0, '0);
        cmp("init_ds_x4", b1.state_o[4], 64'h08090A0B0C0D0E0E);
        idle(1);
        cmp("idle_valid_clear", b1.valid_o, 1'b0);

        // ABSORB_PT then ABSORB_CT back to back
        s = '0;
        s[0] = 64'hFFFFFFFFFFFFFFFF;
        t0 = $time;
        xfer(1, 3'd3, 1'b0, 128'h0F0F0F0F0F0F0F0F, s, 1'b0, '0);
        cmp("pt_x0", b1.state_o[0], 64'hF0F0F0F0F0F0F0F0);
        cmp("pt_cipher", b1.cipher_o, 64'hF0F0F0F0F0F0F0F0);
        s[0] = 64'hAAAAAAAAAAAAAAAA;
        xfer(1, 3'd4, 1'b0, 128'h5555555555555555, s, 1'b0, '0);
        cmp("ct_cipher", b1.cipher_o, 64'hFFFFFFFFFFFFFFFF);
        cmp("ct_x0", b1.state_o[0], 64'h5555555555555555);
        cmp("b2b_time", $time - t0, 20);
        idle(1);

        // FINAL_BEGIN on both rates
        loadkey('1);
        s = '0;
        xfer(1, 3'd5, 1'b0, 128'h0, s, 1'b0, '0);
        cmp("fin1_state", b1.state_o,
            {64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0});
        xfer(2, 3'd5, 1'b0, 128'h1, s, 1'b0, '0);
        cmp("fin2_state", b2.state_o,
            {64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0});
        idle(1);

        // Backpressure: result A held, TAG input B waits three cycles
        for (int i = 0; i < 5; i++) pa[i] = {$urandom, $urandom};
        pb = '0;
        pb[3] = '1;
        pb[4] = '1;
        rdy = 1'b0;
        xfer(1, 3'd0, 1'b0, '0, pa, 1'b0, '0);
        setin(1, 1'b1, 3'd6, 1'b0, '0, pb);
        repeat (3) begin
            @(negedge clk);
            cmp("bp_ready", b1.ready_o, 1'b0);
            cmp("bp_valid", b1.valid_o, 1'b1);
            cmp("bp_state", b1.state_o, pa);
        end
        @(posedge clk);
        #1;
        rdy = 1'b1;
        t0 = $time;
        xfer(1, 3'd6, 1'b0, '0, pb, 1'b1, 128'h0123456789ABCDEFFEDCBA9876543210);
        cmp("bp_accept_time", $time - t0, 10);
        cmp("tag_oldkey", b1.tag_o, '0);
        cmp("tag_valid", b1.tag_valid_o, 1'b1);
        xfer(1, 3'd0, 1'b0, '0, pa, 1'b0, '0);
        cmp("tag_valid_clear", b1.tag_valid_o, 1'b0);
        cmp("tag_hold", b1.tag_o, '0);

        // Illegal op, then sticky error through PASS transfers
        xfer(1, 3'd7, 1'b0, '0, pa, 1'b0, '0);
        cmp("ill_state", b1.state_o, pa);
        cmp("ill_err", b1.err_o, 1'b1);
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
            xfer(1, 3'd0, 1'b0, '0, s, 1'b0, '0);
            cmp("err_sticky", b1.err_o, 1'b1);
        end

        // Mixed random ops on the wide-rate instance
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
            xfer(2, 3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom, $urandom, $urandom}, s, 1'b0, '0);
        end
        idle(2);

        // Asynchronous reset while a result is held
        rdy = 1'b0;
        xfer(1, 3'd2, 1'b0, 128'h1234, pa, 1'b0, '0);
        cmp("hold_valid", b1.valid_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        cmp("mid_rst_valid", b1.valid_o, 1'b0);
        cmp("mid_rst_state", b1.state_o, '0);
        cmp("mid_rst_err", b1.err_o, 1'b0);
        cmp("mid_rst_ready", b1.ready_o, 1'b1);
        q1.delete();
        q2.delete();
        mkey = '0;
        for (int i = 1; i <= 2; i++) begin
            mci[i] = '0; mtag[i] = '0; merr[i] = 1'b0;
        end
        rst = 1'b0;
        rdy = 1'b1;
        @(posedge clk);
        #1;
        xfer(1, 3'd1, 1'b1, 128'h99, pa, 1'b0, '0);
        cmp("post_rst_state", b1.state_o,
            {pa[4] ^ 64'h1, pa[3], pa[2], pa[1], pa[0]});
        idle(2);

        cmp("sb1_drained", q1.size(), 0);
        cmp("sb2_drained", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
